// File: rtl/sad_accum_ctrl.sv
// SAD accumulation controller: accepts pixel pairs over a valid/ready
// handshake, registers |a-b|, sums BLOCK_SIZE differences through one shared
// cla_16bits adder and presents the block SAD on an output handshake.
// Optional feature: define SAD_SATURATE_EN to make the accumulator saturate
// at 16'hFFFF instead of wrapping. ACC_W must stay 16 to match the adder.

module cla_16bits (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Two-level carry lookahead: 4-bit groups with a lookahead unit across groups
  always_comb begin
    g = A & B;
    p = A ^ B;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
              (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = Cin;
    gc[1] = gg[0] | (gp[0] & gc[0]);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
            (gp[2] & gp[1] & gp[0] & gc[0]);
    gc[4] = gg[3] | (gp[3] & gc[3]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = gc[4];
    S     = p ^ c[15:0];
    Cout  = c[16];
  end

endmodule

module sad_accum_ctrl #(
  parameter int PIX_W      = 8,
  parameter int ACC_W      = 16,
  parameter int BLOCK_SIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic [ACC_W-1:0] sad_out,
  output logic             sad_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   diff_q;
  logic               diff_v;
  logic [ACC_W-1:0]   sum;
  logic               cout;
  logic               handshake;
  logic               last_pair;
  logic signed [PIX_W:0] diff_raw;
  logic [PIX_W:0]     diff_neg;
  logic [PIX_W-1:0]   abs_diff;

  // The single shared adder; carry-in is unused, carry-out flags a wrap
  cla_16bits u_cla (
    .A    (acc),
    .B    (diff_q),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // Signed subtract one bit wider than a pixel, then fold negatives back positive
  always_comb begin
    diff_raw  = $signed({1'b0, pix_a}) - $signed({1'b0, pix_b});
    diff_neg  = -diff_raw;
    abs_diff  = diff_raw[PIX_W] ? diff_neg[PIX_W-1:0] : diff_raw[PIX_W-1:0];
    handshake = in_valid & in_ready;
    last_pair = (count == CNT_W'(BLOCK_SIZE - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: DRAIN exists so the last registered diff reaches the accumulator
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = ACC;
      ACC:   if (handshake && last_pair) next_state = DRAIN;
      DRAIN: next_state = DONE;
      DONE:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode purely from state so they are clean right after reset
  always_comb begin
    in_ready  = (state == ACC);
    busy      = (state != IDLE);
    sad_valid = (state == DONE);
    sad_out   = sad_valid ? acc : '0;
  end

  // Difference register and accumulator; a block start clears everything last
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      diff_q   <= '0;
      diff_v   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (diff_v) begin
`ifdef SAD_SATURATE_EN
        if (cout || overflow) acc <= '1;
        else                  acc <= sum;
`else
        acc <= sum;
`endif
        if (cout) overflow <= 1'b1;
      end
      diff_v <= handshake;
      if (handshake) begin
        diff_q <= {{(ACC_W-PIX_W){1'b0}}, abs_diff};
        count  <= count + 1'b1;
      end
      if (state == IDLE && start) begin
        acc      <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_accum_ctrl.sv
// Directed bench for sad_accum_ctrl: three instances (BLOCK_SIZE 16, 300, 1)
// driven with hand-computed vectors. Honours SAD_SATURATE_EN for the wrap case.

module tb_sad_accum_ctrl;

  logic clk;
  logic rst;

  logic        start16, inValid16, inReady16, sadValid16, outReady16, busy16, overflow16;
  logic [7:0]  pixA16, pixB16;
  logic [15:0] sadOut16;

  logic        start300, inValid300, inReady300, sadValid300, outReady300, busy300, overflow300;
  logic [7:0]  pixA300, pixB300;
  logic [15:0] sadOut300;

  logic        start1, inValid1, inReady1, sadValid1, outReady1, busy1, overflow1;
  logic [7:0]  pixA1, pixB1;
  logic [15:0] sadOut1;

  int vectorsApplied = 0;
  int miscompares    = 0;

  sad_accum_ctrl #(.PIX_W(8), .ACC_W(16), .BLOCK_SIZE(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_valid(inValid16), .in_ready(inReady16),
    .pix_a(pixA16), .pix_b(pixB16), .sad_out(sadOut16), .sad_valid(sadValid16),
    .out_ready(outReady16), .busy(busy16), .overflow(overflow16)
  );

  sad_accum_ctrl #(.PIX_W(8), .ACC_W(16), .BLOCK_SIZE(300)) dut300 (
    .clk(clk), .rst(rst), .start(start300), .in_valid(inValid300), .in_ready(inReady300),
    .pix_a(pixA300), .pix_b(pixB300), .sad_out(sadOut300), .sad_valid(sadValid300),
    .out_ready(outReady300), .busy(busy300), .overflow(overflow300)
  );

  sad_accum_ctrl #(.PIX_W(8), .ACC_W(16), .BLOCK_SIZE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(inValid1), .in_ready(inReady1),
    .pix_a(pixA1), .pix_b(pixB1), .sad_out(sadOut1), .sad_valid(sadValid1),
    .out_ready(outReady1), .busy(busy1), .overflow(overflow1)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Run one 16-pair block on dut16; mode 0: (10,3) held, 1: alternating toggled, 2: (255,0) held
  task automatic applyStimulus(input int mode, input int expectSum);
    int accepted;
    int cyc;
    logic v;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    accepted = 0;
    cyc = 0;
    while (accepted < 16 && cyc < 200) begin
      v = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (mode == 0) begin
        pixA16 = 8'd10; pixB16 = 8'd3;
      end else if (mode == 1) begin
        if (accepted % 2 == 0) begin pixA16 = 8'd3;   pixB16 = 8'd10; end
        else                   begin pixA16 = 8'd200; pixB16 = 8'd0;  end
      end else begin
        pixA16 = 8'd255; pixB16 = 8'd0;
      end
      inValid16 = v;
      if (mode == 0) checkOutput("inReadyHeld", {31'b0, inReady16}, 1);
      if (v && inReady16) accepted++;
      tick();
      cyc++;
    end
    inValid16 = 1'b0;
    checkOutput("pairsAccepted", accepted, 16);
    checkOutput("drainSadValid", {31'b0, sadValid16}, 0);
    checkOutput("drainInReady", {31'b0, inReady16}, 0);
    checkOutput("drainBusy", {31'b0, busy16}, 1);
    tick();
    checkOutput("doneSadValid", {31'b0, sadValid16}, 1);
    checkOutput("doneSadOut", {16'b0, sadOut16}, expectSum);
    checkOutput("doneOverflow", {31'b0, overflow16}, 0);
  endtask

  // Stimulus sequence
  initial begin
    int accepted;
    int cyc;
    int busyCount;
    rst = 1'b1;
    {start16, inValid16, outReady16} = '0;
    {start300, inValid300, outReady300} = '0;
    {start1, inValid1, outReady1} = '0;
    pixA16 = '0; pixB16 = '0; pixA300 = '0; pixB300 = '0; pixA1 = '0; pixB1 = '0;

    tick();
    checkOutput("rstInReady", {31'b0, inReady16}, 0);
    checkOutput("rstSadValid", {31'b0, sadValid16}, 0);
    checkOutput("rstSadOut", {16'b0, sadOut16}, 0);
    checkOutput("rstBusy", {31'b0, busy16}, 0);
    checkOutput("rstOverflow", {31'b0, overflow16}, 0);
    checkOutput("rstBusy300", {31'b0, busy300}, 0);
    checkOutput("rstBusy1", {31'b0, busy1}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Uniform block: 16 * 7
    applyStimulus(0, 112);
    outReady16 = 1'b1;
    tick();
    outReady16 = 1'b0;
    checkOutput("releaseSadValid", {31'b0, sadValid16}, 0);

    // Alternating pairs with gappy valid: 8*7 + 8*200
    applyStimulus(1, 1656);

    // Hold DONE with distractions on start and in_valid
    for (int i = 0; i < 5; i++) begin
      outReady16 = 1'b0;
      start16    = (i == 2);
      inValid16  = 1'b1;
      tick();
      checkOutput("holdSadOut", {16'b0, sadOut16}, 1656);
      checkOutput("holdSadValid", {31'b0, sadValid16}, 1);
      checkOutput("holdInReady", {31'b0, inReady16}, 0);
    end
    start16 = 1'b0;
    inValid16 = 1'b0;
    outReady16 = 1'b1;
    tick();
    outReady16 = 1'b0;
    checkOutput("idleSadValid", {31'b0, sadValid16}, 0);
    checkOutput("idleSadOut", {16'b0, sadOut16}, 0);
    checkOutput("idleBusy", {31'b0, busy16}, 0);

    // Abort a block after 7 pairs with reset, then run a clean block
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    inValid16 = 1'b1;
    pixA16 = 8'd50;
    pixB16 = 8'd20;
    for (int i = 0; i < 7; i++) tick();
    inValid16 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abortBusy", {31'b0, busy16}, 0);
    checkOutput("abortInReady", {31'b0, inReady16}, 0);
    checkOutput("abortOverflow", {31'b0, overflow16}, 0);
    applyStimulus(2, 4080);
    outReady16 = 1'b1;
    tick();
    outReady16 = 1'b0;

    // 300 pairs of 255: true sum 76500 exceeds 16 bits
    start300 = 1'b1;
    tick();
    start300 = 1'b0;
    pixA300 = 8'd255;
    pixB300 = 8'd0;
    accepted = 0;
    cyc = 0;
    while (accepted < 300 && cyc < 400) begin
      inValid300 = 1'b1;
      if (inReady300) accepted++;
      tick();
      cyc++;
    end
    inValid300 = 1'b0;
    checkOutput("pairsAccepted300", accepted, 300);
    cyc = 0;
    while (!sadValid300 && cyc < 5) begin
      tick();
      cyc++;
    end
    checkOutput("sadValid300", {31'b0, sadValid300}, 1);
`ifdef SAD_SATURATE_EN
    checkOutput("sadOut300", {16'b0, sadOut300}, 65535);
`else
    checkOutput("sadOut300", {16'b0, sadOut300}, 10964);
`endif
    checkOutput("overflow300", {31'b0, overflow300}, 1);
    outReady300 = 1'b1;
    tick();
    outReady300 = 1'b0;
    checkOutput("idleBusy300", {31'b0, busy300}, 0);

    // Single-pair block: ACC, DRAIN, DONE
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    inValid1 = 1'b1;
    pixA1 = 8'd0;
    pixB1 = 8'd255;
    busyCount = 0;
    cyc = 0;
    while (!sadValid1 && cyc < 10) begin
      if (busy1) busyCount++;
      if (cyc == 0) checkOutput("inReady1", {31'b0, inReady1}, 1);
      tick();
      inValid1 = 1'b0;
      cyc++;
    end
    if (busy1) busyCount++;
    checkOutput("sadValid1", {31'b0, sadValid1}, 1);
    checkOutput("sadOut1", {16'b0, sadOut1}, 255);
    checkOutput("busyCycles1", busyCount, 3);
    outReady1 = 1'b1;
    tick();
    outReady1 = 1'b0;
    checkOutput("idleBusy1", {31'b0, busy1}, 0);
    checkOutput("idleSadValid1", {31'b0, sadValid1}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
